// File: rtl/mod_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter_bank
// Brief    : Bank of CHANNELS modulo-(MAX+1) up/down counters with clear, load
//            and an optional cascade that chains channels into one mixed-radix
//            counter. COUNTER_BANK_ASSERT_EN compiles in embedded properties.
// Revision : 1.0  initial release
// ============================================================================
module mod_counter_bank #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 2,
    parameter int MAX      = 2,
    parameter int CASCADE  = 0
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       down,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS-1:0]       wrap,
    output logic                      carry_out
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    generate
        if ((MAX < 1) || (MAX > (1 << WIDTH) - 1)) begin : g_bad_max
            $error("mod_counter_bank: MAX must lie in 1..2**WIDTH-1");
        end
    endgenerate

    logic [CHANNELS*WIDTH-1:0] r_cnt;
    logic [CHANNELS-1:0]       r_wrap;
    logic                      r_carry;

    logic [CHANNELS*WIDTH-1:0] w_next;
    logic [CHANNELS-1:0]       w_tick;
    logic [WIDTH-1:0]          w_cur;
    logic [WIDTH-1:0]          w_lv;
    logic                      w_step;
    logic                      w_chain;

    // Single loop so the cascade ripples through every channel combinationally;
    // w_chain carries the previous channel's tick (forced high for channel 0).
    always_comb begin
        w_next  = r_cnt;
        w_tick  = '0;
        w_cur   = c_zero;
        w_lv    = c_zero;
        w_step  = 1'b0;
        w_chain = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cur = r_cnt[i*WIDTH +: WIDTH];
            w_lv  = load_val[i*WIDTH +: WIDTH];
            if (w_lv > c_max) begin
                w_lv = c_max;
            end
            w_step = en[i] && ((CASCADE == 0) || w_chain);
            if (clr[i]) begin
                w_next[i*WIDTH +: WIDTH] = c_zero;
            end else if (load[i]) begin
                w_next[i*WIDTH +: WIDTH] = w_lv;
            end else if (w_step) begin
                if (down[i]) begin
                    if (w_cur == c_zero) begin
                        w_next[i*WIDTH +: WIDTH] = c_max;
                        w_tick[i]                = 1'b1;
                    end else begin
                        w_next[i*WIDTH +: WIDTH] = w_cur - c_one;
                    end
                end else begin
                    if (w_cur == c_max) begin
                        w_next[i*WIDTH +: WIDTH] = c_zero;
                        w_tick[i]                = 1'b1;
                    end else begin
                        w_next[i*WIDTH +: WIDTH] = w_cur + c_one;
                    end
                end
            end
            w_chain = w_tick[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_cnt   <= '0;
            r_wrap  <= '0;
            r_carry <= 1'b0;
        end else begin
            r_cnt   <= w_next;
            r_wrap  <= w_tick;
            r_carry <= w_tick[CHANNELS-1];
        end
    end

    assign cnt       = r_cnt;
    assign wrap      = r_wrap;
    assign carry_out = r_carry;

`ifdef COUNTER_BANK_ASSERT_EN
    logic r_past_valid = 1'b0;

    always_ff @(posedge clk) begin
        r_past_valid <= 1'b1;
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_props
            a_range: assert property (@(posedge clk)
                (r_past_valid && $past(reset_)) |-> (cnt[gi*WIDTH +: WIDTH] <= c_max));
            a_wrap_value: assert property (@(posedge clk)
                (r_past_valid && $past(reset_) && wrap[gi]) |->
                (cnt[gi*WIDTH +: WIDTH] == ($past(down[gi]) ? c_max : c_zero)));
            c_wrap_up: cover property (@(posedge clk)
                r_past_valid && $past(reset_) && wrap[gi] && !$past(down[gi]));
            c_wrap_down: cover property (@(posedge clk)
                r_past_valid && $past(reset_) && wrap[gi] && $past(down[gi]));
        end
        if (CASCADE != 0) begin : g_cover_carry
            c_carry: cover property (@(posedge clk)
                r_past_valid && $past(reset_) && carry_out);
        end
    endgenerate

    a_quiet_after_reset: assert property (@(posedge clk)
        (r_past_valid && !$past(reset_)) |-> ((wrap == '0) && !carry_out));
`else
    // Datapath only: no properties compiled in.
`endif

endmodule
`default_nettype wire
